// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 scancode constants, frame FSM encoding and code classification helper
package ps2_pkg;

    localparam logic [7:0] SC_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] SC_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] SC_BAT        = 8'hAA;
    localparam logic [7:0] SC_ACK        = 8'hFA;
    localparam logic [7:0] SC_ECHO       = 8'hEE;
    localparam logic [7:0] SC_RESEND     = 8'hFE;
    localparam logic [7:0] SC_ERR0       = 8'h00;
    localparam logic [7:0] SC_ERR1       = 8'hFF;
    localparam logic [7:0] SC_PAUSE      = 8'hE1;

    // Arrow keys as the game datapath expects them (E0-prefixed on the wire)
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

    // Keyboard status/response bytes that never reach the datapath
    function automatic logic is_ignored_code(input logic [7:0] code);
        return code inside {SC_BAT, SC_ACK, SC_ECHO, SC_RESEND, SC_ERR0, SC_ERR1, SC_PAUSE};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line sync, clock glitch filter, frame FSM and timeout; PS2_PARITY_CHECK_EN adds odd-parity acceptance
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       frame_err
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    frame_state_e     state_q, state_d;
    logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic             filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             fall, timeout, parity_ok, stop_hit;
`ifdef PS2_PARITY_CHECK_EN
    logic             par_q, par_d;
`endif

    // Synchronizers and filter: the accepted clock level flips only after FILTER_LEN differing samples in a row
    always_comb begin
        clk_s1_d    = ps2_clk;
        clk_s2_d    = clk_s1_q;
        dat_s1_d    = ps2_data;
        dat_s2_d    = dat_s1_q;
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FLT_LAST) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        filt_prev_d = filt_q;
        fall        = filt_prev_q & ~filt_q;
    end

    // Line sampling and filter state; idle lines read as 1 out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    // Bit shifting and the inactivity counter; an edge in the timeout cycle wins and restarts the count
    always_comb begin
        timeout   = (state_q != IDLE) && !fall && (to_cnt_q == TO_LAST);
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (fall || timeout || state_q == IDLE) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (fall) begin
            case (state_q)
                IDLE: bit_cnt_d = '0;
                DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
`ifdef PS2_PARITY_CHECK_EN
        par_d = par_q;
        if (fall && state_q == PARITY) begin
            par_d = dat_s2_q;
        end
`endif
    end

    // Frame datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q  <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_q     <= 1'b0;
`endif
        end else begin
            to_cnt_q  <= to_cnt_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q     <= par_d;
`endif
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next state: advance only on accepted falling edges, abandon on timeout
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:    if (!dat_s2_q) state_d = DATA;
                DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame FSM outputs: accept on a good stop bit, flag bad stop/parity or timeout
    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        parity_ok = ^{shift_q, par_q};
`else
        parity_ok = 1'b1;
`endif
        stop_hit  = fall && (state_q == STOP);
        byte_ok   = stop_hit && dat_s2_q && parity_ok;
        frame_err = timeout || (stop_hit && !(dat_s2_q && parity_ok));
        rx_byte   = shift_q;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver with E0/F0 prefix decoding; PS2_PARITY_CHECK_EN enables parity checking
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_ok, rx_err;
    logic [7:0] keycode_q, keycode_d;
    logic       key_make_q, key_make_d, key_ext_q, key_ext_d;
    logic       key_valid_q, key_valid_d, frame_err_q, frame_err_d;
    logic       ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_ok   (rx_ok),
        .frame_err (rx_err)
    );

    // Scancode layer: prefixes arm flags, status bytes are dropped, anything else is a key event
    always_comb begin
        keycode_d   = keycode_q;
        key_make_d  = key_make_q;
        key_ext_d   = key_ext_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        key_valid_d = 1'b0;
        frame_err_d = rx_err;
        if (rx_err) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (rx_ok) begin
            if (rx_byte == SC_PREFIX_EXT) begin
                ext_pend_d = 1'b1;
            end else if (rx_byte == SC_PREFIX_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
                if (!is_ignored_code(rx_byte)) begin
                    keycode_d   = rx_byte;
                    key_make_d  = ~brk_pend_q;
                    key_ext_d   = ext_pend_q;
                    key_valid_d = 1'b1;
                end
            end
        end
    end

    // Held key outputs, pulses and pending prefix flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keycode_q   <= '0;
            key_make_q  <= 1'b0;
            key_ext_q   <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
        end else begin
            keycode_q   <= keycode_d;
            key_make_q  <= key_make_d;
            key_ext_q   <= key_ext_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
        end
    end

    assign keycode   = keycode_q;
    assign key_make  = key_make_q;
    assign key_ext   = key_ext_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - randomized PS/2 frame stimulus checked against a scancode-level event model
module tb_ps2_key_decoder;
    import ps2_pkg::*;

    localparam int FL   = 4;
    localparam int TO   = 400;
    localparam int HALF = 24;
    localparam int LAT  = 2 + FL + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_make, key_ext, key_valid, frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        bit         is_key;
        logic [7:0] code;
        bit         make;
        bit         ext;
        int         at;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        cmp_ev;
    bit         m_ext, m_brk;
    logic [7:0] h_code;
    bit         h_make, h_ext;
    int         kv_cnt = 0;
    int         fe_cnt = 0;
    int         last_err_cyc = 0;
    int         trunc_fall = 0;

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .key_make  (key_make),
        .key_ext   (key_ext),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scancode-level reference: decide the outcome of a complete 11-bit frame
    function automatic void model_frame(input logic [10:0] f, input int at);
        ev_t e;
        bit good;
        logic [7:0] b;
        b    = f[8:1];
        good = (f[0] == 1'b0) && (f[10] == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        good = good && (^f[9:1] == 1'b1);
`endif
        e.is_key = 1'b0; e.code = b; e.make = 1'b0; e.ext = 1'b0; e.at = at;
        if (!good) begin
            exp_q.push_back(e);
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE ||
                     b == 8'h00 || b == 8'hFF || b == 8'hE1) begin
            m_ext = 0; m_brk = 0;
        end else begin
            e.is_key = 1'b1; e.make = !m_brk; e.ext = m_ext;
            exp_q.push_back(e);
            m_ext = 0; m_brk = 0;
        end
    endfunction

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~^b;
        return {~bad_stop, p ^ bad_par, b, 1'b0};
    endfunction

    task automatic drive_bits(input logic [10:0] f, input int n, input int glitch_bit,
                              input int glitch_len, output int last_fall);
        last_fall = 0;
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            if (i == glitch_bit) begin
                repeat (10) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (glitch_len) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HALF - 10 - glitch_len) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b0;
            last_fall = cyc;
            if (i == 10) model_frame(f, cyc + LAT);
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                        input int glitch_bit, input int glitch_len);
        int lf;
        drive_bits(mk_frame(b, bad_par, bad_stop), 11, glitch_bit, glitch_len, lf);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_trunc(input logic [7:0] b, input int n);
        int lf;
        ev_t e;
        drive_bits(mk_frame(b, 1'b0, 1'b0), n, -1, 0, lf);
        ps2_data = 1'b1;
        e.is_key = 1'b0; e.code = 8'h00; e.make = 1'b0; e.ext = 1'b0; e.at = lf + LAT + TO;
        exp_q.push_back(e);
        m_ext = 0; m_brk = 0;
        trunc_fall = lf;
        repeat (TO + 40) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_keycode", keycode, 0);
        chk("rst_key_make", key_make, 0);
        chk("rst_key_ext", key_ext, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        exp_q.delete();
        m_ext = 0; m_brk = 0;
        h_code = 8'h00; h_make = 0; h_ext = 0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Compare process: every pulse must match the next model event at its cycle; held outputs must match
    always @(negedge clk) begin
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missed_event: no pulse at cycle %0d, now %0d", exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
            if (key_valid || frame_err) begin
                if (key_valid) kv_cnt++;
                if (frame_err) begin
                    fe_cnt++;
                    last_err_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {30'b0, key_valid, frame_err}, 0);
                end else begin
                    cmp_ev = exp_q.pop_front();
                    chk("event_cycle", cyc, cmp_ev.at);
                    chk("event_key_valid", key_valid, cmp_ev.is_key);
                    chk("event_frame_err", frame_err, !cmp_ev.is_key);
                    if (cmp_ev.is_key) begin
                        h_code = cmp_ev.code;
                        h_make = cmp_ev.make;
                        h_ext  = cmp_ev.ext;
                    end
                end
            end
            chk("keycode", keycode, h_code);
            chk("key_make", key_make, h_make);
            chk("key_ext", key_ext, h_ext);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, f0, lf;
        logic [7:0] drops [7];
        logic [7:0] arrows [4];
        drops  = '{SC_BAT, SC_ACK, SC_ECHO, SC_RESEND, SC_ERR0, SC_ERR1, SC_PAUSE};
        arrows = '{SC_LEFT, SC_RIGHT, SC_UP, SC_DOWN};

        #5;
        do_reset();

        // Extended make: E0 6B
        k0 = kv_cnt;
        send(8'hE0, 0, 0, -1, 0);
        send(8'h6B, 0, 0, -1, 0);
        chk("tp1_pulses", kv_cnt - k0, 1);
        chk("tp1_code", keycode, 8'h6B);
        chk("tp1_make", key_make, 1);
        chk("tp1_ext", key_ext, 1);

        // Extended break then plain make
        k0 = kv_cnt;
        send(8'hE0, 0, 0, -1, 0);
        send(8'hF0, 0, 0, -1, 0);
        send(8'h6B, 0, 0, -1, 0);
        chk("tp2_pulses", kv_cnt - k0, 1);
        chk("tp2_code", keycode, 8'h6B);
        chk("tp2_make", key_make, 0);
        chk("tp2_ext", key_ext, 1);
        send(8'h1C, 0, 0, -1, 0);
        chk("tp2b_code", keycode, 8'h1C);
        chk("tp2b_make", key_make, 1);
        chk("tp2b_ext", key_ext, 0);

        // Dropped BAT code, then a frame with a 2-clk glitch on ps2_clk
        k0 = kv_cnt;
        send(8'hAA, 0, 0, -1, 0);
        chk("tp3_aa_pulses", kv_cnt - k0, 0);
        send(8'h75, 0, 0, 4, 2);
        chk("tp3_pulses", kv_cnt - k0, 1);
        chk("tp3_code", keycode, 8'h75);
        chk("tp3_ext", key_ext, 0);

        // A lone clock pulse with data high is ignored in IDLE
        k0 = kv_cnt;
        f0 = fe_cnt;
        drive_bits(11'h7FF, 1, -1, 0, lf);
        repeat (40) @(negedge clk);
        chk("idle_pulse_kv", kv_cnt - k0, 0);
        chk("idle_pulse_fe", fe_cnt - f0, 0);

        // Timeout after start + 5 data bits; also drops the pending E0
        send(8'hE0, 0, 0, -1, 0);
        f0 = fe_cnt;
        send_trunc(8'h55, 6);
        chk("tp4_err_count", fe_cnt - f0, 1);
        chk("tp4_err_delay", last_err_cyc - trunc_fall, 407);
        send(8'h72, 0, 0, -1, 0);
        chk("tp4_code", keycode, 8'h72);
        chk("tp4_ext", key_ext, 0);

        // Bad stop bit, then bad parity
        k0 = kv_cnt;
        f0 = fe_cnt;
        send(8'h74, 0, 1, -1, 0);
        chk("tp5_stop_fe", fe_cnt - f0, 1);
        chk("tp5_stop_kv", kv_cnt - k0, 0);
        chk("tp5_stop_code", keycode, 8'h72);
        k0 = kv_cnt;
        f0 = fe_cnt;
        send(8'h74, 1, 0, -1, 0);
`ifdef PS2_PARITY_CHECK_EN
        chk("tp5_par_fe", fe_cnt - f0, 1);
        chk("tp5_par_kv", kv_cnt - k0, 0);
        chk("tp5_par_code", keycode, 8'h72);
`else
        chk("tp5_par_fe", fe_cnt - f0, 0);
        chk("tp5_par_kv", kv_cnt - k0, 1);
        chk("tp5_par_code", keycode, 8'h74);
`endif

        // Reset in the middle of an E0 frame
        drive_bits(mk_frame(8'hE0, 0, 0), 5, -1, 0, lf);
        do_reset();
        send(8'h6B, 0, 0, -1, 0);
        chk("tp6_code", keycode, 8'h6B);
        chk("tp6_make", key_make, 1);
        chk("tp6_ext", key_ext, 0);

        // Randomized traffic against the model
        for (int r = 0; r < 60; r++) begin
            int sel;
            logic [7:0] b;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = SC_PREFIX_EXT;
                1:       b = SC_PREFIX_BRK;
                2:       b = drops[$urandom_range(0, 6)];
                3, 4:    b = arrows[$urandom_range(0, 3)];
                default: b = 8'($urandom);
            endcase
            if ($urandom_range(0, 24) == 0) begin
                send_trunc(b, $urandom_range(1, 10));
            end else begin
                send(b, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1,
                     $urandom_range(1, FL - 1));
            end
        end

        repeat (40) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Receive side of the PS/2 keyboard link. Samples the raw ps2_clk/ps2_data lines and assembles 11-bit device-to-host frames. Decodes the E0 (extended) and F0 (break) scancode prefixes and presents keycode/key_make/key_ext to the game datapath, which samples them as levels under its key-capture enable.

Parameters:
FILTER_LEN, 4, consecutive equal synced samples required before the ps2_clk level is accepted (glitch filter)
TIMEOUT_CYCLES, 10000, clk cycles with no accepted falling edge before a partial frame is abandoned (200 us at 50 MHz)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock line, asynchronous
ps2_data  input  1  raw PS/2 data line, asynchronous
keycode  output  8  last decoded scancode, held until the next code
key_make  output  1  1 = make (press), 0 = break (release); held with keycode
key_ext  output  1  1 = code was E0-prefixed; held with keycode
key_valid  output  1  one-cycle pulse when keycode/key_make/key_ext update
frame_err  output  1  one-cycle pulse on a bad start/stop bit, a timeout, or (with the option) a parity failure

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM in IDLE; prefix flags cleared; filter and timeout counters 0; sync flops 1.
- ps2_clk and ps2_data each pass through 2-flop synchronizers. The filtered clock level changes only after FILTER_LEN consecutive equal synced samples. A falling edge is a filtered 1->0 transition; ps2_data is sampled (synced) in the same cycle.
- Frame FSM, advancing only on falling edges:
  - IDLE: data=0 -> DATA with bit_cnt=0. data=1 -> stay in IDLE, no error.
  - DATA: shift data in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: data=1 -> byte_ok, go to IDLE. data=0 -> frame_err, drop the byte, go to IDLE.
- Timeout: in any non-IDLE state, the counter increments each clk and clears on every falling edge. On reaching TIMEOUT_CYCLES: go to IDLE, pulse frame_err, clear prefix flags.
- Scancode layer, acting on byte_ok:
  - E0: set ext_pend.
  - F0: set brk_pend.
  - AA, FA, EE, FE, 00, FF, E1: dropped; both flags cleared.
  - Any other byte: keycode <= byte, key_make <= ~brk_pend, key_ext <= ext_pend, key_valid pulses, both flags cleared.
- Latency: key_valid, and the new keycode/key_make/key_ext, appear on the clk edge after the STOP-bit falling edge is detected. At least 2+FILTER_LEN+1 clks after the raw ps2_clk fall.
- Simultaneous events:
  - A timeout and a falling edge in the same cycle: the edge wins and the counter clears.
  - A frame error or timeout clears ext_pend and brk_pend.
- Pause key (E1 sequence) is not supported: E1 is dropped and the following bytes decode as ordinary codes.
- keycode/key_make/key_ext never change except with key_valid or reset.

Optional Feature:
PS2_PARITY_CHECK_EN
- Defined: in STOP, the frame is accepted only if the 8 data bits plus the parity bit have odd parity. On failure: byte dropped, frame_err pulses, prefix flags cleared.
- Undefined: the parity bit is captured but ignored; no parity logic is synthesized.

Decomposition:
- Package ps2_pkg holds:
  - Scancode constants: SC_PREFIX_EXT=8'hE0, SC_PREFIX_BRK=8'hF0, SC_BAT=8'hAA, SC_ACK=8'hFA, SC_ECHO=8'hEE, SC_RESEND=8'hFE, SC_ERR0=8'h00, SC_ERR1=8'hFF, SC_PAUSE=8'hE1.
  - Arrow codes matching the datapath: 6B/74/75/72.
  - The frame FSM state encoding: IDLE, DATA, PARITY, STOP.
- Sub-module ps2_frame_rx contains the synchronizers, filter, frame FSM, timeout counter, and parity check; it emits byte, byte_ok, and frame_err.
- ps2_key_decoder instantiates ps2_frame_rx and adds the prefix/scancode layer.

Test Plan:
1. Frames E0, 6B (valid parity/stop, ps2_clk at 12.5 kHz) -> one key_valid; keycode=6B, key_make=1, key_ext=1.
2. Frames E0, F0, 6B -> one key_valid; keycode=6B, key_make=0, key_ext=1. Then frame 1C -> keycode=1C, key_make=1, key_ext=0.
3. Frame AA, then 75 -> no pulse for AA; one key_valid with keycode=75, key_ext=0. Also: a 2-clk low glitch on ps2_clk mid-frame -> no bit advance, byte decodes correctly.
4. Start bit plus 5 data bits, then idle lines -> frame_err pulses exactly TIMEOUT_CYCLES after the last edge; a following frame 72 decodes with keycode=72.
5. Frame 74 with stop bit=0 -> frame_err pulse, outputs unchanged. With PS2_PARITY_CHECK_EN: frame 74 with wrong parity -> frame_err, no key_valid; without the macro -> key_valid, keycode=74.
6. Reset asserted after 4 data bits of E0 -> outputs 0 immediately. After release, frame 6B -> key_ext=0 (prefix was lost).
